// File: rtl/vx_flush_ctrl.sv
// vx_flush_ctrl -- per-bank tag-store flush sequencer.
//
// Walks every line index of one cache bank and issues one invalidating
// write per cycle into the tag access stage's fill/flush port. A sweep
// runs once automatically after reset (INIT, no completion response)
// and once per accepted flush request (SWEEP, followed by a completion
// response in RESP). Core lookups are held off through `busy` whenever
// the sequencer is not IDLE.
//
// Handshakes: a transfer happens on a rising clock edge where both valid
// and ready are high. The requester keeps flush_req_valid high until it
// sees flush_req_ready; the sequencer keeps flush_rsp_valid high until
// it sees flush_rsp_ready. Neither ready depends combinationally on the
// matching valid, and no request is ever queued.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   flush_req_valid/ready   flush request handshake (ready only in IDLE)
//   flush_rsp_valid/ready   flush completion handshake
//   stall              tag store owned by the pipeline; no write this cycle
//   busy               high unless IDLE; blocks core lookups
//   flush_valid        drives the tag stage `fill` and `is_flush`
//   flush_addr         line address; low CNTW bits are the line counter
//   perf_flush_stalls  (FLUSH_PERF_EN only) saturating count of stalled
//                      sweep cycles, cleared only by reset
//   dbg_state_o        current FSM state for debug/checkers
//
// Optional feature macro: FLUSH_PERF_EN.
module vx_flush_ctrl #(
    parameter int CACHE_ID        = 0,
    parameter int BANK_ID         = 0,
    parameter int CACHE_SIZE      = 16384,
    parameter int CACHE_LINE_SIZE = 64,
    parameter int NUM_BANKS       = 4,
    parameter int WORD_SIZE       = 4,
    localparam int LINES           = CACHE_SIZE / (CACHE_LINE_SIZE * NUM_BANKS),
    localparam int CNTW            = (LINES > 1) ? $clog2(LINES) : 1,
    localparam int LINE_ADDR_WIDTH = 32 - $clog2(CACHE_LINE_SIZE)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_req_valid,
    output logic                       flush_req_ready,
    output logic                       flush_rsp_valid,
    input  logic                       flush_rsp_ready,
    input  logic                       stall,
    output logic                       busy,
    output logic                       flush_valid,
    output logic [LINE_ADDR_WIDTH-1:0] flush_addr,
`ifdef FLUSH_PERF_EN
    output logic [31:0]                perf_flush_stalls,
`endif
    output logic [1:0]                 dbg_state_o
);

    // Reject configurations that cannot produce a meaningful sweep.
    if (LINES < 1 || WORD_SIZE < 1 || WORD_SIZE > CACHE_LINE_SIZE ||
        CACHE_ID < 0 || BANK_ID < 0 || CNTW > LINE_ADDR_WIDTH) begin : g_bad_cfg
        $error("vx_flush_ctrl: invalid cache geometry");
    end

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_SWEEP = 2'd1,
        S_RESP  = 2'd2,
        S_IDLE  = 2'd3
    } state_e;

    localparam logic [CNTW-1:0] LAST_LINE = CNTW'(LINES - 1);

    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            sweeping;

    assign sweeping = (state_q == S_INIT) || (state_q == S_SWEEP);

    // Next-state logic. The counter only moves on cycles that actually
    // write, so a stall holds the current line address.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_INIT, S_SWEEP: begin
                if (!stall) begin
                    if (cnt_q == LAST_LINE) begin
                        cnt_d   = '0;
                        state_d = (state_q == S_INIT) ? S_IDLE : S_RESP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_IDLE: begin
                if (flush_req_valid) begin
                    state_d = S_SWEEP;
                    cnt_d   = '0;
                end
            end
            S_RESP: begin
                if (flush_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output decode from registered state. Reset forces the quiescent
    // values combinationally so the tag stage never sees a write while
    // reset is asserted, even on the first reset cycle.
    always_comb begin
        flush_valid     = 1'b0;
        flush_req_ready = 1'b0;
        flush_rsp_valid = 1'b0;
        busy            = 1'b1;
        flush_addr      = '0;
        if (!reset) begin
            flush_addr = LINE_ADDR_WIDTH'(cnt_q);
            unique case (state_q)
                S_INIT, S_SWEEP: flush_valid = !stall;
                S_RESP:          flush_rsp_valid = 1'b1;
                S_IDLE: begin
                    flush_req_ready = 1'b1;
                    busy            = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign dbg_state_o = state_q;

`ifdef FLUSH_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= '0;
        end else if (sweeping && stall && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_flush_stalls = perf_q;
`else
    // Without the perf counter the sweep flag only feeds nothing; keep it
    // referenced so the decode stays shared between builds.
    logic unused_sweeping;
    assign unused_sweeping = sweeping;
`endif

endmodule
